spi_slave_rx_tx: RTL and testbench

SPI mode-0 responder for the SPI/Wishbone subsystem: the far end of the bus clocked by the divided serial clock. It receives an externally driven SCLK, CS_N and MOSI, synchronises them into the CLK domain, and shifts frames in and out MSB first. It delivers received words with a one-cycle strobe and accepts transmit words through a valid/ready handshake.

---
 rtl/spi_slave_rx_tx.sv | 196 +++++++++++++++++++
 tb/tb_spi_slave_rx_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_tx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx_tx
// SPI mode-0 (CPOL=0, CPHA=0) responder. SCLK, CS_N and MOSI arrive
// asynchronously and are synchronised into the CLK domain. Frames are shifted
// MSB first. Received words are reported with a one-cycle strobe. Transmit words
// are written into a single-entry holding register through a valid/ready
// handshake.
//
// Ports
//   CLK          system clock, all logic on its rising edge
//   RST          synchronous active-high reset
//   SCLK         serial clock from the master, idles low
//   CS_N         chip select from the master, active low
//   MOSI         serial data from the master
//   MISO         serial data to the master (registered)
//   TX_DATA      word to send in the next frame
//   TX_VALID     TX_DATA valid
//   TX_READY     holding register empty
//   RX_DATA      last complete received word
//   RX_VALID     one-cycle strobe, RX_DATA just updated
//   TX_UNDERRUN  one-cycle strobe, a frame started with the holding register empty
//   BUSY         high while a frame is in progress
// -----------------------------------------------------------------------------
module spi_slave_rx_tx #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SCLK,
    input  logic              CS_N,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              TX_VALID,
    output logic              TX_READY,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_VALID,
    output logic              TX_UNDERRUN,
    output logic              BUSY
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    // Synchronisers. They are left out of reset so that a pin held steady
    // through reset does not look like an edge when reset is released.
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic cs_n_s1_q, cs_n_s2_q, cs_n_s3_q;
    logic mosi_s1_q, mosi_s2_q;

    always_ff @(posedge CLK) begin
        sclk_s1_q <= SCLK;
        sclk_s2_q <= sclk_s1_q;
        sclk_s3_q <= sclk_s2_q;
        cs_n_s1_q <= CS_N;
        cs_n_s2_q <= cs_n_s1_q;
        cs_n_s3_q <= cs_n_s2_q;
        mosi_s1_q <= MOSI;
        mosi_s2_q <= mosi_s1_q;
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
    assign cs_rise   = cs_n_s2_q & ~cs_n_s3_q;
    assign cs_fall   = ~cs_n_s2_q & cs_n_s3_q;

    // rx_shift holds the bits collected so far (never more than DATA_W-1);
    // tx_shift holds the bits still to send after the one already on MISO.
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-2:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              frame_done_q, frame_done_d;
    logic              miso_q, miso_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;

    logic              consume;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] load_word;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        frame_done_d = frame_done_q;
        miso_d       = miso_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        underrun_d   = 1'b0;
        consume      = 1'b0;
        rx_next      = {rx_shift_q, mosi_s2_q};
        load_word    = hold_full_q ? hold_q : '0;

        if (cs_rise) begin
            // Deselect wins over everything: a partial word is dropped.
            state_d      = ST_IDLE;
            bit_cnt_d    = '0;
            rx_shift_d   = '0;
            tx_shift_d   = '0;
            frame_done_d = 1'b0;
            miso_d       = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (cs_fall) begin
                state_d      = ST_ACTIVE;
                consume      = 1'b1;
                bit_cnt_d    = '0;
                rx_shift_d   = '0;
                frame_done_d = 1'b0;
            end
        end else begin
            if (sclk_rise) begin
                rx_shift_d = rx_next[DATA_W-2:0];
                if (bit_cnt_q == LAST_BIT) begin
                    rx_data_d    = rx_next;
                    rx_valid_d   = 1'b1;
                    bit_cnt_d    = '0;
                    frame_done_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            if (sclk_fall) begin
                if (frame_done_q) begin
                    // Back-to-back frame: the next word goes out on this fall.
                    consume      = 1'b1;
                    frame_done_d = 1'b0;
                end else begin
                    miso_d     = tx_shift_q[DATA_W-2];
                    tx_shift_d = tx_shift_q << 1;
                end
            end
        end

        // Consumption sees the holding register as it was before any write in
        // the same cycle, so a simultaneous write is kept for the next frame.
        if (consume) begin
            miso_d      = load_word[DATA_W-1];
            tx_shift_d  = load_word[DATA_W-2:0];
            underrun_d  = ~hold_full_q;
            hold_full_d = 1'b0;
        end
        if (TX_VALID && !hold_full_q) begin
            hold_d      = TX_DATA;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            frame_done_q <= 1'b0;
            miso_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            frame_done_q <= frame_done_d;
            miso_q       <= miso_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            underrun_q   <= underrun_d;
        end
    end

    assign MISO        = miso_q;
    assign TX_READY    = ~hold_full_q;
    assign RX_DATA     = rx_data_q;
    assign RX_VALID    = rx_valid_q;
    assign TX_UNDERRUN = underrun_q;
    assign BUSY        = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rx_tx
// Drives the responder as an SPI mode-0 master with half periods of 4 CLK
// cycles. Expected values come from a vector table, hand-built sequences, and a
// word-level model of the holding register for the random frames.
// -----------------------------------------------------------------------------
module tb_spi_slave_rx_tx;

    logic       clk = 1'b0;
    logic       rst, sclk, cs_n, mosi, miso;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, tx_underrun, busy;

    always #5 clk = ~clk;

    spi_slave_rx_tx #(.DATA_W(8)) dut (
        .CLK        (clk),
        .RST        (rst),
        .SCLK       (sclk),
        .CS_N       (cs_n),
        .MOSI       (mosi),
        .MISO       (miso),
        .TX_DATA    (tx_data),
        .TX_VALID   (tx_valid),
        .TX_READY   (tx_ready),
        .RX_DATA    (rx_data),
        .RX_VALID   (rx_valid),
        .TX_UNDERRUN(tx_underrun),
        .BUSY       (busy)
    );

    int         n_checks = 0;
    int         n_errs   = 0;
    int         ur_cnt   = 0;
    logic [7:0] rx_q[$];

    // Every high sample of RX_VALID records a word, so a strobe wider than one
    // cycle shows up as an extra word.
    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (tx_underrun) ur_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] w);
        int t = 0;
        while (!tx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!tx_ready) begin
            n_checks++;
            n_errs++;
            $display("FAIL tx_ready_timeout: TX_READY=0 after 200 cycles, expected 1");
        end
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        wait_clk(4);
    endtask

    // Clocks nbits bits MSB first. With end_frame set, CS_N rises together with
    // the last SCLK fall so the responder does not begin another frame.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit end_frame,
                            output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi  = mo[i];
            wait_clk(4);
            mi[i] = miso;
            sclk  = 1'b1;
            wait_clk(4);
            if (end_frame && i == 8 - nbits) cs_n = 1'b1;
            sclk = 1'b0;
        end
        if (end_frame) wait_clk(6);
    endtask

    function automatic logic [7:0] pop_rx();
        if (rx_q.size() > 0) return rx_q.pop_front();
        return 8'hxx;
    endfunction

    typedef struct {
        bit         load;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_mi;
        logic [7:0] exp_rx;
        int         exp_ur;
    } vec_t;

    initial begin
        vec_t       vecs[5];
        logic [7:0] mi, mi2, w, mo, exp_mi;
        logic [7:0] exp_rx_q[$];
        int         ur0, nfr, exp_ur;
        bit         model_full;
        logic [7:0] model_word;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
        vecs[1] = '{1'b0, 8'h00, 8'hC3, 8'h00, 8'hC3, 1};
        vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 0};
        vecs[3] = '{1'b1, 8'h01, 8'h80, 8'h01, 8'h80, 0};
        vecs[4] = '{1'b1, 8'h5A, 8'hFF, 8'h5A, 8'hFF, 0};

        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00;
        wait_clk(5);
        check("rst_miso", miso, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_underrun", tx_underrun, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        wait_clk(3);
        ur_cnt = 0;
        rx_q.delete();

        // Table-driven single frames
        for (int k = 0; k < 5; k++) begin
            ur0 = ur_cnt;
            rx_q.delete();
            if (vecs[k].load) push_tx(vecs[k].tx);
            cs_start();
            check($sformatf("v%0d_busy_in", k), busy, 1);
            check($sformatf("v%0d_tx_ready_in", k), tx_ready, 1);
            spi_bits(vecs[k].mo, 8, 1'b1, mi);
            check($sformatf("v%0d_miso_word", k), mi, vecs[k].exp_mi);
            check($sformatf("v%0d_rx_count", k), rx_q.size(), 1);
            check($sformatf("v%0d_rx_word", k), pop_rx(), vecs[k].exp_rx);
            check($sformatf("v%0d_rx_data", k), rx_data, vecs[k].exp_rx);
            check($sformatf("v%0d_underrun", k), ur_cnt - ur0, vecs[k].exp_ur);
            check($sformatf("v%0d_busy_out", k), busy, 0);
            check($sformatf("v%0d_miso_idle", k), miso, 0);
        end

        // Back-to-back frames, second TX word loaded during the first frame
        ur0 = ur_cnt;
        rx_q.delete();
        push_tx(8'h81);
        cs_start();
        fork
            begin
                spi_bits(8'h5C, 8, 1'b0, mi);
                spi_bits(8'hE7, 8, 1'b1, mi2);
            end
            begin
                wait_clk(20);
                push_tx(8'h7E);
            end
        join
        check("b2b_miso1", mi, 8'h81);
        check("b2b_miso2", mi2, 8'h7E);
        check("b2b_rx_count", rx_q.size(), 2);
        check("b2b_rx1", pop_rx(), 8'h5C);
        check("b2b_rx2", pop_rx(), 8'hE7);
        check("b2b_underrun", ur_cnt - ur0, 0);

        // Abort after 5 SCLK rises
        ur0 = ur_cnt;
        rx_q.delete();
        cs_start();
        spi_bits(8'hAA, 5, 1'b1, mi);
        check("abort_rx_count", rx_q.size(), 0);
        check("abort_rx_data_held", rx_data, 8'hE7);
        check("abort_miso", miso, 0);
        check("abort_busy", busy, 0);
        check("abort_underrun", ur_cnt - ur0, 1);
        rx_q.delete();
        cs_start();
        spi_bits(8'h6D, 8, 1'b1, mi);
        check("post_abort_rx", pop_rx(), 8'h6D);
        check("post_abort_miso", mi, 8'h00);

        // Reset three bits into a frame with a word waiting in the holding register
        push_tx(8'hFF);
        cs_start();
        fork
            spi_bits(8'h12, 3, 1'b0, mi);
            begin
                wait_clk(10);
                push_tx(8'h34);
            end
        join
        wait_clk(4);
        check("pre_rst_miso", miso, 1);
        check("pre_rst_tx_ready", tx_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_miso", miso, 0);
        check("mid_rst_tx_ready", tx_ready, 1);
        check("mid_rst_rx_data", rx_data, 0);
        check("mid_rst_rx_valid", rx_valid, 0);
        check("mid_rst_underrun", tx_underrun, 0);
        check("mid_rst_busy", busy, 0);
        rst = 1'b0;
        wait_clk(2);
        rx_q.delete();
        ur0 = ur_cnt;
        spi_bits(8'hFF, 8, 1'b0, mi);
        wait_clk(6);
        check("post_rst_sclk_rx_count", rx_q.size(), 0);
        check("post_rst_sclk_busy", busy, 0);
        check("post_rst_sclk_underrun", ur_cnt - ur0, 0);
        cs_n = 1'b1;
        wait_clk(6);
        push_tx(8'h96);
        cs_start();
        spi_bits(8'h69, 8, 1'b1, mi);
        check("post_rst_frame_miso", mi, 8'h96);
        check("post_rst_frame_rx", pop_rx(), 8'h69);

        // TX write in the very cycle the frame start consumes an empty register
        ur0 = ur_cnt;
        rx_q.delete();
        check("simul_ready_before", tx_ready, 1);
        cs_n = 1'b0;
        wait_clk(2);
        tx_data  = 8'hC9;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("simul_word_held", tx_ready, 0);
        wait_clk(1);
        spi_bits(8'h11, 8, 1'b1, mi);
        check("simul_miso_zero", mi, 8'h00);
        check("simul_underrun", ur_cnt - ur0, 1);
        check("simul_rx", pop_rx(), 8'h11);
        ur0 = ur_cnt;
        cs_start();
        spi_bits(8'h22, 8, 1'b1, mi);
        check("simul_next_miso", mi, 8'hC9);
        check("simul_next_underrun", ur_cnt - ur0, 0);
        check("simul_next_rx", pop_rx(), 8'h22);

        // Random sessions of one or two frames against the holding-register model
        check("rand_ready_start", tx_ready, 1);
        model_full = 1'b0;
        model_word = 8'h00;
        for (int r = 0; r < 14; r++) begin
            ur0 = ur_cnt;
            exp_ur = 0;
            rx_q.delete();
            exp_rx_q.delete();
            if ($urandom_range(0, 1) == 1) begin
                w = 8'($urandom);
                push_tx(w);
                model_full = 1'b1;
                model_word = w;
            end
            nfr = $urandom_range(1, 2);
            cs_start();
            for (int f = 0; f < nfr; f++) begin
                mo     = 8'($urandom);
                exp_mi = model_full ? model_word : 8'h00;
                if (!model_full) exp_ur++;
                model_full = 1'b0;
                exp_rx_q.push_back(mo);
                spi_bits(mo, 8, f == nfr - 1, mi);
                check($sformatf("rand%0d_f%0d_miso", r, f), mi, exp_mi);
            end
            check($sformatf("rand%0d_rx_count", r), rx_q.size(), nfr);
            for (int f = 0; f < nfr; f++)
                check($sformatf("rand%0d_f%0d_rx", r, f), pop_rx(), exp_rx_q[f]);
            check($sformatf("rand%0d_underrun", r), ur_cnt - ur0, exp_ur);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
